// File: rtl/accelerator_dnc_pkg.sv
// rtl/accelerator_dnc_pkg.sv - shared run-state enum and PLAN sigmoid constants for the DNC read-heads path
package accelerator_dnc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } run_state_e;

    localparam logic [127:0] PLAN_ZERO = '0;

    // Constants scaled by 2^fract; fract must be at least 5 so every offset stays integral.
    function automatic logic [127:0] plan_one(input int fract);
        return 128'd1 << fract;
    endfunction

    function automatic logic [127:0] plan_bp_hi(input int fract);
        return 128'd5 << fract;
    endfunction

    function automatic logic [127:0] plan_bp_mid(input int fract);
        return 128'd19 << (fract - 3);
    endfunction

    function automatic logic [127:0] plan_bp_lo(input int fract);
        return 128'd1 << fract;
    endfunction

    function automatic logic [127:0] plan_off_hi(input int fract);
        return 128'd27 << (fract - 5);
    endfunction

    function automatic logic [127:0] plan_off_mid(input int fract);
        return 128'd5 << (fract - 3);
    endfunction

    function automatic logic [127:0] plan_off_lo(input int fract);
        return 128'd1 << (fract - 1);
    endfunction

endpackage

// File: rtl/accelerator_plan_sigmoid.sv
// rtl/accelerator_plan_sigmoid.sv - combinational PLAN sigmoid on signed fixed point, result clamped to [0, ONE]
module accelerator_plan_sigmoid
    import accelerator_dnc_pkg::*;
#(
    parameter int DATA_SIZE  = 64,
    parameter int FRACT_SIZE = 16
) (
    input  logic [DATA_SIZE-1:0] x,
    output logic [DATA_SIZE-1:0] y
);

    localparam logic [DATA_SIZE-1:0] ONE      = DATA_SIZE'(plan_one(FRACT_SIZE));
    localparam logic [DATA_SIZE-1:0] ZERO     = DATA_SIZE'(PLAN_ZERO);
    localparam logic [DATA_SIZE-1:0] BP_HI    = DATA_SIZE'(plan_bp_hi(FRACT_SIZE));
    localparam logic [DATA_SIZE-1:0] BP_MID   = DATA_SIZE'(plan_bp_mid(FRACT_SIZE));
    localparam logic [DATA_SIZE-1:0] BP_LO    = DATA_SIZE'(plan_bp_lo(FRACT_SIZE));
    localparam logic [DATA_SIZE-1:0] OFF_HI   = DATA_SIZE'(plan_off_hi(FRACT_SIZE));
    localparam logic [DATA_SIZE-1:0] OFF_MID  = DATA_SIZE'(plan_off_mid(FRACT_SIZE));
    localparam logic [DATA_SIZE-1:0] OFF_LO   = DATA_SIZE'(plan_off_lo(FRACT_SIZE));
    localparam logic [DATA_SIZE-1:0] MOST_NEG = {1'b1, {(DATA_SIZE-1){1'b0}}};

    logic                 neg;
    logic [DATA_SIZE-1:0] a;
    logic [DATA_SIZE-1:0] mag;
    logic [DATA_SIZE-1:0] res;

    always_comb begin
        neg = x[DATA_SIZE-1];
        a   = neg ? (~x + DATA_SIZE'(1)) : x;

        if (a >= BP_HI) begin
            mag = ONE;
        end else if (a >= BP_MID) begin
            mag = (a >> 5) + OFF_HI;
        end else if (a >= BP_LO) begin
            mag = (a >> 3) + OFF_MID;
        end else begin
            mag = (a >> 2) + OFF_LO;
        end

        res = neg ? (ONE - mag) : mag;

        // The most-negative input has no positive magnitude, so it is pinned to zero.
        if (x == MOST_NEG || res[DATA_SIZE-1]) begin
            y = ZERO;
        end else if (res > ONE) begin
            y = ONE;
        end else begin
            y = res;
        end
    end

endmodule

// File: rtl/accelerator_free_gates_multihead.sv
// rtl/accelerator_free_gates_multihead.sv - streaming multi-head free-gate unit: run FSM, head counter, registered sigmoid output
// Optional sticky ERROR output enabled by defining ACCELERATOR_FREE_GATES_ERROR_EN.
module accelerator_free_gates_multihead
    import accelerator_dnc_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int FRACT_SIZE   = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
`ifdef ACCELERATOR_FREE_GATES_ERROR_EN
    output logic                    ERROR,
`endif
    input  logic                    F_IN_ENABLE,
    output logic                    F_OUT_ENABLE,
    input  logic [DATA_SIZE-1:0]    SIZE_R_IN,
    input  logic [DATA_SIZE-1:0]    F_IN,
    output logic [DATA_SIZE-1:0]    F_OUT,
    output logic [CONTROL_SIZE-1:0] F_OUT_INDEX
);

    localparam logic [DATA_SIZE-1:0] ZERO = DATA_SIZE'(PLAN_ZERO);

    run_state_e              state_q, state_d;
    logic [DATA_SIZE-1:0]    r_q, r_d;
    logic [CONTROL_SIZE-1:0] cnt_q, cnt_d;
    logic [DATA_SIZE-1:0]    f_out_q, f_out_d;
    logic                    f_en_q, f_en_d;
    logic [CONTROL_SIZE-1:0] idx_q, idx_d;
    logic [DATA_SIZE-1:0]    sig_y;

    accelerator_plan_sigmoid #(
        .DATA_SIZE  (DATA_SIZE),
        .FRACT_SIZE (FRACT_SIZE)
    ) u_sigmoid (
        .x (F_IN),
        .y (sig_y)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        f_out_d = f_out_q;
        f_en_d  = 1'b0;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    r_d     = SIZE_R_IN;
                    cnt_d   = '0;
                    state_d = (SIZE_R_IN == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (F_IN_ENABLE) begin
                    f_out_d = sig_y;
                    f_en_d  = 1'b1;
                    idx_d   = cnt_q;
                    cnt_d   = cnt_q + CONTROL_SIZE'(1);
                    if (DATA_SIZE'(cnt_d) == r_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            r_q     <= '0;
            cnt_q   <= '0;
            f_out_q <= ZERO;
            f_en_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            f_out_q <= f_out_d;
            f_en_q  <= f_en_d;
            idx_q   <= idx_d;
        end
    end

    // DONE is entered on the last accept, so it lines up with the last registered output.
    assign READY        = (state_q == DONE);
    assign F_OUT        = f_out_q;
    assign F_OUT_ENABLE = f_en_q;
    assign F_OUT_INDEX  = idx_q;

`ifdef ACCELERATOR_FREE_GATES_ERROR_EN
    logic error_q, error_d;
    logic err_evt;

    always_comb begin
        err_evt = (F_IN_ENABLE && state_q != RUN) || (START && state_q == RUN);
        error_d = ((START && state_q == IDLE) ? 1'b0 : error_q) | err_evt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign ERROR = error_q;
`endif

endmodule

// File: tb/tb_accelerator_free_gates_multihead.sv
// tb/tb_accelerator_free_gates_multihead.sv - directed and randomized self-checking bench for the free-gate unit
module tb_accelerator_free_gates_multihead;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        READY;
    logic        F_IN_ENABLE = 1'b0;
    logic        F_OUT_ENABLE;
    logic [63:0] SIZE_R_IN = '0;
    logic [63:0] F_IN = '0;
    logic [63:0] F_OUT;
    logic [63:0] F_OUT_INDEX;
`ifdef ACCELERATOR_FREE_GATES_ERROR_EN
    logic        ERROR;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    accelerator_free_gates_multihead dut (
        .CLK          (CLK),
        .RST          (RST),
        .START        (START),
        .READY        (READY),
`ifdef ACCELERATOR_FREE_GATES_ERROR_EN
        .ERROR        (ERROR),
`endif
        .F_IN_ENABLE  (F_IN_ENABLE),
        .F_OUT_ENABLE (F_OUT_ENABLE),
        .SIZE_R_IN    (SIZE_R_IN),
        .F_IN         (F_IN),
        .F_OUT        (F_OUT),
        .F_OUT_INDEX  (F_OUT_INDEX)
    );

    initial forever #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference sigmoid in Q.16 using plain integer arithmetic on real-valued breakpoints.
    function automatic logic [63:0] model_sig(input logic [63:0] xin);
        longint x, a, y;
        if (xin == 64'h8000_0000_0000_0000) return 64'd0;
        x = longint'(xin);
        a = (x < 0) ? -x : x;
        if (a >= 5 * 65536)             y = 65536;
        else if (a * 8 >= 19 * 65536)   y = a / 32 + (27 * 65536) / 32;
        else if (a >= 65536)            y = a / 8 + (5 * 65536) / 8;
        else                            y = a / 4 + 65536 / 2;
        if (x < 0) y = 65536 - y;
        if (y < 0) y = 0;
        if (y > 65536) y = 65536;
        return 64'(y);
    endfunction

    function automatic logic [63:0] rand_x();
        logic [63:0] v;
        logic [63:0] bps[6];
        bps = '{64'd327680, 64'd327679, 64'd155648, 64'd155647, 64'd65536, 64'd65535};
        case ($urandom_range(0, 3))
            0:       v = {$urandom, $urandom};
            1:       v = 64'(longint'($urandom_range(0, 786432)) - 64'sd393216);
            2:       v = bps[$urandom_range(0, 5)];
            default: v = 64'(longint'($urandom_range(0, 8)) - 64'sd4);
        endcase
        if ($urandom_range(0, 1) == 1) v = ~v + 64'd1;
        return v;
    endfunction

    task automatic do_run(input int r, input logic [63:0] xs[$], input int gap);
        logic [63:0] exp_last;
        START = 1'b1;
        SIZE_R_IN = 64'(r);
        tick();
        START = 1'b0;
        if (r == 0) begin
            check("r0_ready", {63'd0, READY}, 64'd1);
            check("r0_fen", {63'd0, F_OUT_ENABLE}, 64'd0);
            tick();
            check("r0_ready_drop", {63'd0, READY}, 64'd0);
            check("r0_fen_after", {63'd0, F_OUT_ENABLE}, 64'd0);
            return;
        end
        for (int i = 0; i < r; i++) begin
            F_IN_ENABLE = 1'b1;
            F_IN = xs[i];
            tick();
            F_IN_ENABLE = 1'b0;
            exp_last = model_sig(xs[i]);
            check("f_en", {63'd0, F_OUT_ENABLE}, 64'd1);
            check("f_out", F_OUT, exp_last);
            check("f_idx", F_OUT_INDEX, 64'(i));
            check("ready", {63'd0, READY}, {63'd0, i == r - 1});
            if (i < r - 1) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    check("gap_en", {63'd0, F_OUT_ENABLE}, 64'd0);
                    check("gap_hold", F_OUT, exp_last);
                    check("gap_ready", {63'd0, READY}, 64'd0);
                end
            end
        end
        tick();
        check("post_ready", {63'd0, READY}, 64'd0);
        check("post_en", {63'd0, F_OUT_ENABLE}, 64'd0);
    endtask

    initial begin
        logic [63:0] xs[$];
        int r;

        tick();
        tick();
        check("rst_ready", {63'd0, READY}, 64'd0);
        check("rst_fen", {63'd0, F_OUT_ENABLE}, 64'd0);
        check("rst_fout", F_OUT, 64'd0);
        check("rst_idx", F_OUT_INDEX, 64'd0);
        RST = 1'b0;
        tick();

        xs = '{64'd0, 64'd65536, 64'hFFFF_FFFF_FFFF_0000, 64'd131072};
        do_run(4, xs, 0);
        check("t1_last_out", F_OUT, 64'd57344);

        xs = '{64'd393216, 64'hFFFF_FFFF_FFF8_0000, 64'h8000_0000_0000_0000};
        do_run(3, xs, 0);
        check("t2_most_neg", F_OUT, 64'd0);

        do_run(0, xs, 0);

        xs = '{64'd32768, 64'hFFFF_FFFF_FFFD_0000, 64'd200000};
        do_run(3, xs, 2);

        START = 1'b1;
        SIZE_R_IN = 64'd4;
        tick();
        START = 1'b0;
        for (int i = 0; i < 2; i++) begin
            F_IN_ENABLE = 1'b1;
            F_IN = 64'd65536;
            tick();
            F_IN_ENABLE = 1'b0;
            check("t5_pre_idx", F_OUT_INDEX, 64'(i));
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("t5_rst_fout", F_OUT, 64'd0);
        check("t5_rst_fen", {63'd0, F_OUT_ENABLE}, 64'd0);
        check("t5_rst_idx", F_OUT_INDEX, 64'd0);
        check("t5_rst_ready", {63'd0, READY}, 64'd0);
        tick();
        check("t5_no_ready", {63'd0, READY}, 64'd0);
        xs = '{64'hFFFF_FFFF_FFFF_8000};
        do_run(1, xs, 0);

        F_IN_ENABLE = 1'b1;
        F_IN = 64'd65536;
        tick();
        F_IN_ENABLE = 1'b0;
        check("idle_en_ignored", {63'd0, F_OUT_ENABLE}, 64'd0);
`ifdef ACCELERATOR_FREE_GATES_ERROR_EN
        check("err_set", {63'd0, ERROR}, 64'd1);
        tick();
        tick();
        check("err_hold", {63'd0, ERROR}, 64'd1);
        START = 1'b1;
        SIZE_R_IN = 64'd1;
        tick();
        START = 1'b0;
        check("err_clear", {63'd0, ERROR}, 64'd0);
        F_IN_ENABLE = 1'b1;
        F_IN = 64'd0;
        tick();
        F_IN_ENABLE = 1'b0;
        check("err_run_out", F_OUT, 64'd32768);
        tick();
`endif

        START = 1'b1;
        F_IN_ENABLE = 1'b1;
        F_IN = 64'd65536;
        SIZE_R_IN = 64'd1;
        tick();
        START = 1'b0;
        F_IN_ENABLE = 1'b0;
        check("sim_start_drop", {63'd0, F_OUT_ENABLE}, 64'd0);
        F_IN_ENABLE = 1'b1;
        F_IN = 64'd0;
        tick();
        F_IN_ENABLE = 1'b0;
        check("sim_start_idx", F_OUT_INDEX, 64'd0);
        check("sim_start_out", F_OUT, 64'd32768);
        check("sim_start_ready", {63'd0, READY}, 64'd1);
        tick();

        for (int k = 0; k < 8; k++) begin
            r = $urandom_range(1, 6);
            xs.delete();
            for (int i = 0; i < r; i++) xs.push_back(rand_x());
            do_run(r, xs, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
